// File: rtl/l2_pkg.sv
// Shared widths and FSM encoding for the L2 tag/control block.
package l2_pkg;
  localparam int L1_TAG_W = 20;
  localparam int L1_IDX_W = 6;
  localparam int L2_IDX_W = 8;
  localparam int BLK_W    = L1_TAG_W + L1_IDX_W;
  localparam int L2_TAG_W = BLK_W - L2_IDX_W;
  localparam int L2_SETS  = 1 << L2_IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    RESPOND,
    DRAIN
  } state_t;
endpackage

// File: rtl/l2_controller_if.sv
// L1 request, memory and data-array strobe bundle of the L2 controller.
interface l2_controller_if;
  import l2_pkg::*;

  logic                read_L1_L2;
  logic                write_L1_L2;
  logic [L1_IDX_W-1:0] index_L1_L2;
  logic [L1_TAG_W-1:0] tag_L1_L2;
  logic [L1_TAG_W-1:0] write_tag_L1_L2;
  logic                flush;
  logic                ready_MEM_L2;
  logic                ready_L2_L1;
  logic                busy;
  logic                read_L2_MEM;
  logic                write_L2_MEM;
  logic [BLK_W-1:0]    addr_L2_MEM;
  logic [L2_IDX_W-1:0] index_L2;
  logic                refill_L2;
  logic                update_L2;

  modport slave (
    input  read_L1_L2, write_L1_L2, index_L1_L2,
    input  tag_L1_L2, write_tag_L1_L2, flush,
    input  ready_MEM_L2,
    output ready_L2_L1, busy, read_L2_MEM,
    output write_L2_MEM, addr_L2_MEM, index_L2,
    output refill_L2, update_L2
  );

  modport master (
    output read_L1_L2, write_L1_L2, index_L1_L2,
    output tag_L1_L2, write_tag_L1_L2, flush,
    output ready_MEM_L2,
    input  ready_L2_L1, busy, read_L2_MEM,
    input  write_L2_MEM, addr_L2_MEM, index_L2,
    input  refill_L2, update_L2
  );
endinterface

// File: rtl/l2_tag_array.sv
// L2 tag/valid/dirty storage: one async read port, one write port,
// dirty set/clear and a whole-array invalidate.
module l2_tag_array
  import l2_pkg::*;
(
  input  logic                clk,
  input  logic                nrst,
  input  logic [L2_IDX_W-1:0] idx,
  output logic [L2_TAG_W-1:0] rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                wr_en,
  input  logic [L2_TAG_W-1:0] wr_tag,
  input  logic                wr_dirty,
  input  logic                set_dirty,
  input  logic                clr_dirty,
  input  logic                flush_all
);
  logic [L2_TAG_W-1:0] tags [L2_SETS];
  logic [L2_SETS-1:0]  valid;
  logic [L2_SETS-1:0]  dirty;

  assign rd_tag   = tags[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];

  // tags carry no reset; valid guards them
  always_ff @(posedge clk) begin
    if (wr_en)
      tags[idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (!nrst || flush_all) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (wr_en) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= wr_dirty;
      end
      if (set_dirty)
        dirty[idx] <= 1'b1;
      if (clr_dirty)
        dirty[idx] <= 1'b0;
    end
  end
endmodule

// File: rtl/l2_controller.sv
// Direct-mapped write-back L2 control FSM serving L1 fills and
// victim write-backs, with memory write-back/fetch on a miss.
module l2_controller
  import l2_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  l2_controller_if.slave bus
);
  state_t state;
  state_t nxt;

  logic [BLK_W-1:0]    blk;
  logic                op_wr;
  logic                refill_q;
  logic                update_q;
  logic [L2_IDX_W-1:0] idx;
  logic [L2_TAG_W-1:0] req_tag;
  logic [L2_TAG_W-1:0] tag_rd;
  logic                v_rd;
  logic                d_rd;
  logic                hit;
  logic                victim_dirty;
  logic                take;
  logic                flush_all;
  logic                mem_done;
  logic                wr_en;
  logic                wr_dirty;
  logic                set_dirty;
  logic                clr_dirty;
  logic                do_update;
  logic                do_refill;

  assign idx          = blk[L2_IDX_W-1:0];
  assign req_tag      = blk[BLK_W-1:L2_IDX_W];
  assign hit          = v_rd && (tag_rd == req_tag);
  assign victim_dirty = v_rd && d_rd && !hit;
  assign mem_done     = bus.ready_MEM_L2;
  assign flush_all    = (state == IDLE) && bus.flush;
  assign take         = (state == IDLE) && !bus.flush
                     && (bus.read_L1_L2 || bus.write_L1_L2);

  // a clean write miss installs the full L1 line with no fetch
  assign wr_en     = ((state == COMPARE) && op_wr && !hit && !victim_dirty)
                  || ((state == ALLOCATE) && mem_done);
  assign wr_dirty  = (state == COMPARE);
  assign set_dirty = (state == COMPARE) && op_wr && hit;
  assign clr_dirty = (state == WRITE_BACK) && mem_done;
  assign do_update = (state == COMPARE) && op_wr && !victim_dirty;
  assign do_refill = (state == ALLOCATE) && mem_done;

  l2_tag_array u_tags (
    .clk       (clk),
    .nrst      (nrst),
    .idx       (idx),
    .rd_tag    (tag_rd),
    .rd_valid  (v_rd),
    .rd_dirty  (d_rd),
    .wr_en     (wr_en),
    .wr_tag    (req_tag),
    .wr_dirty  (wr_dirty),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .flush_all (flush_all)
  );

  always_ff @(posedge clk) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:       if (take) nxt = COMPARE;
      COMPARE: begin
        if (hit)               nxt = RESPOND;
        else if (victim_dirty) nxt = WRITE_BACK;
        else if (op_wr)        nxt = RESPOND;
        else                   nxt = ALLOCATE;
      end
      WRITE_BACK: if (mem_done) nxt = COMPARE;
      ALLOCATE:   if (mem_done) nxt = COMPARE;
      RESPOND:    nxt = DRAIN;
      DRAIN:      nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  // write wins when both requests are up; the read is taken later
  always_ff @(posedge clk) begin
    if (!nrst) begin
      blk      <= '0;
      op_wr    <= 1'b0;
      refill_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      refill_q <= do_refill;
      update_q <= do_update;
      if (take) begin
        op_wr <= bus.write_L1_L2;
        blk   <= bus.write_L1_L2
               ? {bus.write_tag_L1_L2, bus.index_L1_L2}
               : {bus.tag_L1_L2, bus.index_L1_L2};
      end
    end
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.ready_L2_L1  = (state == RESPOND);
    bus.read_L2_MEM  = (state == ALLOCATE);
    bus.write_L2_MEM = (state == WRITE_BACK);
    bus.addr_L2_MEM  = '0;
    bus.index_L2     = idx;
    bus.refill_L2    = refill_q;
    bus.update_L2    = update_q;
    unique case (1'b1)
      (state == WRITE_BACK): bus.addr_L2_MEM = {tag_rd, idx};
      (state == ALLOCATE):   bus.addr_L2_MEM = blk;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l2_controller.sv
// Directed bench for l2_controller with a transaction-level cache model.
module tb_l2_controller;
  import l2_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  l2_controller_if bus();

  l2_controller dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  logic [L2_TAG_W-1:0] m_tag [L2_SETS];
  bit                  m_val [L2_SETS];
  bit                  m_dir [L2_SETS];

  int vectors = 0;
  int miscompares = 0;

  logic [BLK_W-1:0]    exp_wb_addr;
  logic [BLK_W-1:0]    exp_fetch_addr;
  logic [L2_IDX_W-1:0] exp_set;
  bit exp_wb, exp_fetch, exp_upd, exp_hit;

  int tot_ready = 0, tot_ref = 0, tot_upd = 0;
  int exp_ready = 0, exp_ref_n = 0, exp_upd_n = 0;

  bit wb_seen, fetch_seen;
  int obs_upd, obs_ref, obs_rdy, obs_lat;
  int first_wb, first_fetch;
  logic [BLK_W-1:0] obs_wb_addr, obs_fetch_addr;

  function automatic void chk(input string n, input logic [31:0] a,
                              input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < L2_SETS; s++) begin
      m_val[s] = 1'b0;
      m_dir[s] = 1'b0;
    end
  endfunction

  function automatic void predict(input bit wr, input logic [19:0] t,
                                  input logic [5:0] i);
    logic [BLK_W-1:0]    b;
    logic [L2_IDX_W-1:0] s;
    logic [L2_TAG_W-1:0] lt;
    b = {t, i};
    s = b[L2_IDX_W-1:0];
    lt = b[BLK_W-1:L2_IDX_W];
    exp_set = s;
    exp_hit = m_val[s] && (m_tag[s] == lt);
    exp_wb = m_val[s] && m_dir[s] && !exp_hit;
    exp_wb_addr = {m_tag[s], s};
    exp_fetch = !wr && !exp_hit;
    exp_fetch_addr = b;
    exp_upd = wr;
  endfunction

  function automatic void commit(input bit wr, input logic [19:0] t,
                                 input logic [5:0] i);
    logic [BLK_W-1:0] b;
    b = {t, i};
    if (wr || !exp_hit) begin
      m_tag[b[L2_IDX_W-1:0]] = b[BLK_W-1:L2_IDX_W];
      m_val[b[L2_IDX_W-1:0]] = 1'b1;
      m_dir[b[L2_IDX_W-1:0]] = wr;
    end
  endfunction

  // per-cycle output checks against the current expectation
  always @(negedge clk) begin
    if (bus.write_L2_MEM) begin
      chk("wb_addr", bus.addr_L2_MEM, exp_wb_addr);
      chk("mem_excl", bus.read_L2_MEM, 0);
    end else if (bus.read_L2_MEM)
      chk("fetch_addr", bus.addr_L2_MEM, exp_fetch_addr);
    else
      chk("addr_zero", bus.addr_L2_MEM, 0);
    if (bus.busy)
      chk("index_L2", bus.index_L2, exp_set);
    else
      chk("idle_outputs", {bus.ready_L2_L1, bus.refill_L2,
          bus.update_L2, bus.read_L2_MEM, bus.write_L2_MEM}, 0);
    tot_ready += int'(bus.ready_L2_L1);
    tot_ref += int'(bus.refill_L2);
    tot_upd += int'(bus.update_L2);
  end

  task automatic run_req(input bit wr, input logic [19:0] t,
                         input logic [5:0] i, input int lat,
                         input bit keep_rd, input logic [19:0] rt);
    int memwait;
    int rdy_at;
    bit done;
    predict(wr, t, i);
    wb_seen = 0; fetch_seen = 0;
    obs_upd = 0; obs_ref = 0; obs_rdy = 0; obs_lat = -1;
    first_wb = -1; first_fetch = -1;
    obs_wb_addr = '0; obs_fetch_addr = '0;
    memwait = 0; rdy_at = -1; done = 0;
    bus.index_L1_L2 = i;
    bus.write_L1_L2 = wr;
    bus.read_L1_L2 = !wr || keep_rd;
    if (wr) begin
      bus.write_tag_L1_L2 = t;
      bus.tag_L1_L2 = keep_rd ? rt : 20'hFFFFF;
    end else begin
      bus.tag_L1_L2 = t;
      bus.write_tag_L1_L2 = 20'hFFFFF;
    end
    for (int c = 1; c <= 300 && !done; c++) begin
      @(posedge clk); #1;
      if (bus.ready_MEM_L2) begin
        bus.ready_MEM_L2 = 1'b0;
        memwait = 0;
      end else if (bus.read_L2_MEM || bus.write_L2_MEM) begin
        memwait++;
        if (memwait >= lat) bus.ready_MEM_L2 = 1'b1;
      end
      if (bus.write_L2_MEM && !wb_seen) begin
        wb_seen = 1; first_wb = c; obs_wb_addr = bus.addr_L2_MEM;
      end
      if (bus.read_L2_MEM && !fetch_seen) begin
        fetch_seen = 1; first_fetch = c;
        obs_fetch_addr = bus.addr_L2_MEM;
      end
      obs_upd += int'(bus.update_L2);
      obs_ref += int'(bus.refill_L2);
      if (bus.ready_L2_L1) begin
        obs_rdy++;
        if (rdy_at < 0) rdy_at = c;
      end
      // L1 holds its registered request one cycle past ready
      if (rdy_at > 0 && c == rdy_at + 2) done = 1;
    end
    bus.write_L1_L2 = 1'b0;
    bus.read_L1_L2 = wr && keep_rd;
    bus.ready_MEM_L2 = 1'b0;
    obs_lat = rdy_at;
    chk("ready_count", obs_rdy, 1);
    chk("writeback", wb_seen, exp_wb);
    chk("fetch", fetch_seen, exp_fetch);
    chk("update", obs_upd, exp_upd);
    chk("refill", obs_ref, exp_fetch);
    if (exp_wb && exp_fetch)
      chk("wb_before_fetch", first_wb < first_fetch, 1);
    if (exp_hit)
      chk("hit_latency", rdy_at, 2);
    commit(wr, t, i);
    exp_ready++;
    exp_ref_n += int'(exp_fetch);
    exp_upd_n += int'(exp_upd);
  endtask

  initial begin
    bit seen;
    bus.read_L1_L2 = 0; bus.write_L1_L2 = 0;
    bus.index_L1_L2 = '0; bus.tag_L1_L2 = '0;
    bus.write_tag_L1_L2 = '0; bus.flush = 0;
    bus.ready_MEM_L2 = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {bus.busy, bus.ready_L2_L1, bus.read_L2_MEM,
        bus.write_L2_MEM, bus.refill_L2, bus.update_L2}, 0);
    chk("reset_addr", bus.addr_L2_MEM, 0);
    chk("reset_index", bus.index_L2, 0);
    nrst = 1'b1;

    // 1: cold read miss
    run_req(0, 20'h12345, 6'h05, 3, 0, '0);
    chk("t1_fetch_addr", obs_fetch_addr, 26'h048D145);
    // 2: same read hits
    run_req(0, 20'h12345, 6'h05, 1, 0, '0);
    chk("t2_latency", obs_lat, 2);
    chk("t2_no_mem", {wb_seen, fetch_seen}, 0);
    // 3: victim write hit, then conflicting read
    run_req(1, 20'h12345, 6'h05, 1, 0, '0);
    chk("t3_update", obs_upd, 1);
    run_req(0, 20'h22345, 6'h05, 2, 0, '0);
    chk("t3_wb_addr", obs_wb_addr, 26'h048D145);
    chk("t3_fetch_addr", obs_fetch_addr, 26'h088D145);
    // 4: write and read together
    run_req(1, 20'h22345, 6'h05, 2, 1, 20'h00ABC);
    run_req(0, 20'h00ABC, 6'h05, 4, 0, '0);
    chk("t4_fetch_addr", obs_fetch_addr, 26'h002AF05);
    // write miss over a dirty victim, then read it back
    run_req(1, 20'h32345, 6'h05, 2, 0, '0);
    chk("wm_wb_addr", obs_wb_addr, 26'h088D145);
    chk("wm_no_fetch", fetch_seen, 0);
    run_req(0, 20'h32345, 6'h05, 1, 0, '0);
    // 5: flush drops dirty lines silently
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_idle", bus.busy, 0);
    model_clear();
    run_req(0, 20'h12345, 6'h05, 2, 0, '0);
    chk("t5_no_wb", wb_seen, 0);
    // 6: reset in the middle of a fetch
    predict(0, 20'h0F0F0, 6'h2A);
    bus.tag_L1_L2 = 20'h0F0F0;
    bus.index_L1_L2 = 6'h2A;
    bus.read_L1_L2 = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = bus.read_L2_MEM;
    end
    chk("t6_alloc_reached", seen, 1);
    @(posedge clk); #1;
    nrst = 1'b0;
    bus.read_L1_L2 = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_ctrl", {bus.busy, bus.ready_L2_L1, bus.read_L2_MEM,
        bus.write_L2_MEM, bus.refill_L2, bus.update_L2}, 0);
    chk("t6_reset_addr", bus.addr_L2_MEM, 0);
    nrst = 1'b1;
    model_clear();
    bus.ready_MEM_L2 = 1'b1;
    @(posedge clk); #1;
    bus.ready_MEM_L2 = 1'b0;
    chk("t6_late_ready", {bus.busy, bus.refill_L2}, 0);
    @(posedge clk); #1;
    chk("t6_still_idle", bus.busy, 0);
    run_req(0, 20'h0F0F0, 6'h2A, 2, 0, '0);
    chk("t6_refetch", obs_fetch_addr, 26'h03C3C2A);
    run_req(0, 20'h12345, 6'h05, 1, 0, '0);
    chk("t6_post_reset_miss", fetch_seen, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("total_ready", tot_ready, exp_ready);
    chk("total_refill", tot_ref, exp_ref_n);
    chk("total_update", tot_upd, exp_upd_n);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
